// File: rtl/operand_seq_pkg.sv
//------------------------------------------------------------------------------
// Module  : operand_seq_pkg
// Brief   : Shared types and constants for operand_sequencer. Frame length
//           depends on EXPECT_CHECK_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package operand_seq_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        EVAL = 2'd1,
        OUT  = 2'd2
    } state_e;

    localparam logic [1:0] IDX_X2  = 2'd0;
    localparam logic [1:0] IDX_X1  = 2'd1;
    localparam logic [1:0] IDX_X0  = 2'd2;
    localparam logic [1:0] IDX_EXP = 2'd3;

`ifdef EXPECT_CHECK_EN
    localparam int FRAME_LEN = 4;
`else
    localparam int FRAME_LEN = 3;
`endif

    localparam logic [1:0] IDX_LAST = 2'(FRAME_LEN - 1);

endpackage

`default_nettype wire

// File: rtl/operand_sequencer.sv
//------------------------------------------------------------------------------
// Module  : operand_sequencer
// Brief   : Serial operand loader / result catcher around a combinational
//           arithmetic unit. Optional macro EXPECT_CHECK_EN adds an expected-
//           value nibble per frame and drives res_match.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module operand_sequencer
    import operand_seq_pkg::*;
#(
    parameter int W           = 4,
    parameter int EVAL_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] X2,
    output logic [W-1:0] X1,
    output logic [W-1:0] X0,
    input  logic [W-1:0] F,
    output logic [W-1:0] res_data,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         res_match,
    output logic         busy
);

    localparam logic [3:0] C_EVAL = 4'(EVAL_CYCLES);

    state_e       state_q, state_d;
    logic [1:0]   idx_q, idx_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [W-1:0] x2_q, x2_d, x1_q, x1_d, x0_q, x0_d;
    logic [W-1:0] res_data_q, res_data_d;
    logic         res_valid_q, res_valid_d;
`ifdef EXPECT_CHECK_EN
    logic [W-1:0] exp_q, exp_d;
    logic         match_q, match_d;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        x2_d        = x2_q;
        x1_d        = x1_q;
        x0_d        = x0_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
`ifdef EXPECT_CHECK_EN
        exp_d       = exp_q;
        match_d     = match_q;
`endif
        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    case (idx_q)
                        IDX_X2:  x2_d = in_data;
                        IDX_X1:  x1_d = in_data;
                        IDX_X0:  x0_d = in_data;
`ifdef EXPECT_CHECK_EN
                        IDX_EXP: exp_d = in_data;
`endif
                        default: ;
                    endcase
                    if (idx_q == IDX_LAST) begin
                        idx_d   = 2'd0;
                        cnt_d   = C_EVAL;
                        state_d = EVAL;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            EVAL: begin
                // Counter runs down to zero so F is sampled EVAL_CYCLES+1 edges after the last operand.
                if (cnt_q == 4'd0) begin
                    res_data_d  = F;
                    res_valid_d = 1'b1;
`ifdef EXPECT_CHECK_EN
                    match_d     = (F == exp_q);
`endif
                    state_d     = OUT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
`ifdef EXPECT_CHECK_EN
                    match_d     = 1'b0;
`endif
                    state_d     = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            idx_q       <= 2'd0;
            cnt_q       <= 4'd0;
            x2_q        <= '0;
            x1_q        <= '0;
            x0_q        <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
`ifdef EXPECT_CHECK_EN
            exp_q       <= '0;
            match_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            x2_q        <= x2_d;
            x1_q        <= x1_d;
            x0_q        <= x0_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
`ifdef EXPECT_CHECK_EN
            exp_q       <= exp_d;
            match_q     <= match_d;
`endif
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign busy      = (state_q != LOAD) || (idx_q != 2'd0);
    assign X2        = x2_q;
    assign X1        = x1_q;
    assign X0        = x0_q;
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;
`ifdef EXPECT_CHECK_EN
    assign res_match = match_q;
`else
    assign res_match = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_operand_sequencer.sv
//------------------------------------------------------------------------------
// Module  : tb_operand_sequencer
// Brief   : Self-checking bench for operand_sequencer with a stand-in
//           combinational arithmetic unit on X2/X1/X0 -> F.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_operand_sequencer;

    localparam int W    = 4;
    localparam int EVAL = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] X2, X1, X0, F;
    logic [W-1:0] res_data;
    logic         res_valid;
    logic         res_ready;
    logic         res_match;
    logic         busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in arithmetic unit: depends on all three operands.
    assign F = ((X2 & X1) ^ X0) + X1;

    operand_sequencer #(.W(W), .EVAL_CYCLES(EVAL)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .X2(X2), .X1(X1), .X0(X0), .F(F),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .res_match(res_match), .busy(busy)
    );

    function automatic logic [W-1:0] ref_f(input logic [W-1:0] a, b, c);
        int v;
        v = ((a & b) ^ c) + b;
        return W'(v % 16);
    endfunction

    function automatic logic ref_match(input logic [W-1:0] f, e);
`ifdef EXPECT_CHECK_EN
        return (f == e);
`else
        return 1'b0;
`endif
    endfunction

    task automatic send_nib(input logic [W-1:0] d, input int max_gap, output int hs_edge);
        int g;
        g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (g) begin
            in_valid = 1'b0;
            in_data  = W'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        g = 0;
        while (!in_ready && g < 100) begin @(posedge clk); #1; g++; end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL in_ready_wait got=%b want=1", in_ready);
        end
        @(posedge clk); #1;
        hs_edge  = cyc;
        in_valid = 1'b0;
        in_data  = W'($urandom);
    endtask

    task automatic send_frame(input logic [W-1:0] a, b, c, e, input int max_gap, output int last);
        send_nib(a, max_gap, last);
        send_nib(b, max_gap, last);
        send_nib(c, max_gap, last);
`ifdef EXPECT_CHECK_EN
        send_nib(e, max_gap, last);
`endif
    endtask

    // Waits for the result, checks it, stalls, accepts. hold_next keeps the next
    // frame's first nibble presented on the input while the result is pending.
    task automatic check_result(input logic [W-1:0] a, b, c, e, input int last, input int stall,
                                input bit noise, input bit hold_next, input logic [W-1:0] nxt);
        int g;
        logic [W-1:0] want;
        want = ref_f(a, b, c);
        res_ready = (stall == 0);
        g = 0;
        while (!res_valid && g < 60) begin
            if (hold_next) begin in_valid = 1'b1; in_data = nxt; end
            else if (noise) begin in_valid = 1'($urandom); in_data = W'($urandom); end
            @(posedge clk); #1; g++;
        end
        total++;
        if (res_valid !== 1'b1 || cyc != last + EVAL + 1) begin
            bad++;
            $display("FAIL latency got_edge=%0d valid=%b want_edge=%0d", cyc - last, res_valid, EVAL + 1);
        end
        total++;
        if (res_data !== want) begin
            bad++;
            $display("FAIL res_data got=%h want=%h", res_data, want);
        end
        total++;
        if (res_match !== ref_match(want, e)) begin
            bad++;
            $display("FAIL res_match got=%b want=%b", res_match, ref_match(want, e));
        end
        total++;
        if (X2 !== a || X1 !== b || X0 !== c) begin
            bad++;
            $display("FAIL x_regs got=%h%h%h want=%h%h%h", X2, X1, X0, a, b, c);
        end
        for (int i = 0; i < stall; i++) begin
            if (hold_next) begin in_valid = 1'b1; in_data = nxt; end
            else if (noise) begin in_valid = 1'($urandom); in_data = W'($urandom); end
            @(posedge clk); #1;
            total++;
            if (res_valid !== 1'b1 || res_data !== want || in_ready !== 1'b0 || X2 !== a) begin
                bad++;
                $display("FAIL stall_hold got v=%b d=%h rdy=%b x2=%h want v=1 d=%h rdy=0 x2=%h",
                         res_valid, res_data, in_ready, X2, want, a);
            end
        end
        if (!hold_next) in_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        total++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1 || res_match !== 1'b0) begin
            bad++;
            $display("FAIL accept got v=%b rdy=%b m=%b want v=0 rdy=1 m=0", res_valid, in_ready, res_match);
        end
        if (!hold_next) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
            total++;
            if (busy !== 1'b0 || in_ready !== 1'b1 || X2 !== a || X1 !== b || X0 !== c) begin
                bad++;
                $display("FAIL idle_after got busy=%b rdy=%b x=%h%h%h want busy=0 rdy=1 x=%h%h%h",
                         busy, in_ready, X2, X1, X0, a, b, c);
            end
        end
    endtask

    task automatic check_idle(input string name);
        total++;
        if (X2 !== '0 || X1 !== '0 || X0 !== '0 || res_data !== '0 || res_valid !== 1'b0 ||
            res_match !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s got x=%h%h%h d=%h v=%b m=%b rdy=%b busy=%b want all 0, rdy=1",
                     name, X2, X1, X0, res_data, res_valid, res_match, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset_values");
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle("after_reset");
    endtask

    task automatic test_basic();
        int last;
        send_frame(4'b1100, 4'b0011, 4'b0100, 4'b0111, 0, last);
        check_result(4'b1100, 4'b0011, 4'b0100, 4'b0111, last, 0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_backpressure();
        int last;
        send_frame(4'b1100, 4'b0011, 4'b0100, 4'b0111, 0, last);
        check_result(4'b1100, 4'b0011, 4'b0100, 4'b0111, last, 5, 1'b0, 1'b0, '0);
    endtask

    task automatic test_expect();
        int last;
        send_frame(4'b1100, 4'b0011, 4'b0100, 4'b0110, 1, last);
        check_result(4'b1100, 4'b0011, 4'b0100, 4'b0110, last, 1, 1'b0, 1'b0, '0);
    endtask

    task automatic test_random_gaps();
        int last;
        logic [W-1:0] a, b, c, e;
        for (int n = 0; n < 8; n++) begin
            a = W'($urandom); b = W'($urandom); c = W'($urandom);
            e = $urandom_range(1, 0) ? ref_f(a, b, c) : W'($urandom);
            send_frame(a, b, c, e, 3, last);
            check_result(a, b, c, e, last, int'($urandom_range(3, 0)), 1'b1, 1'b0, '0);
        end
    endtask

    task automatic test_reset_mid();
        int last;
        send_nib(4'b1100, 0, last);
        send_nib(4'b0011, 0, last);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle("mid_reset");
        send_frame(4'b0101, 4'b0110, 4'b1001, 4'b0000, 1, last);
        check_result(4'b0101, 4'b0110, 4'b1001, 4'b0000, last, 2, 1'b0, 1'b0, '0);
    endtask

    task automatic test_back_to_back();
        int last;
        send_frame(4'b1100, 4'b0011, 4'b0100, 4'b0111, 0, last);
        check_result(4'b1100, 4'b0011, 4'b0100, 4'b0111, last, 3, 1'b0, 1'b1, 4'b0000);
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (X2 !== 4'b0000 || X1 !== 4'b0011 || busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first_nibble got x2=%h x1=%h busy=%b want x2=0 x1=3 busy=1", X2, X1, busy);
        end
        send_nib(4'b0000, 0, last);
        send_nib(4'b0000, 0, last);
`ifdef EXPECT_CHECK_EN
        send_nib(4'b0000, 0, last);
`endif
        check_result(4'b0000, 4'b0000, 4'b0000, 4'b0000, last, 0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_expect();
        test_random_gaps();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
